axi3_rd_arbiter: RTL and testbench
==================================

Name: axi3_rd_arbiter

Overview:
- Two-requester, single-outstanding round-robin arbiter sharing the 64-bit AXI3 m00 read channel (AR + R) between two upstream read masters, e.g. a BP DMA engine and a host-debug reader.
- Sits between the requesters and the m00_axi_ar*/r* ports of top_fpga; the write channel is unaffected.
- Holds one grant for a whole burst, routes R beats back to the owner, flags protocol errors.

Parameters:
ADDR_WIDTH, 32, AR address width
DATA_WIDTH, 64, R data width
ID_WIDTH, 6, AXI3 ID width (arid/rid)

Ports:
m00_axi_aclk  in  1  clock
m00_axi_aresetn  in  1  synchronous active-low reset
s0_/s1_ araddr  in  ADDR_WIDTH  requester read address
s0_/s1_ arlen  in  4  AXI3 burst length minus 1
s0_/s1_ arsize  in  3  beat size
s0_/s1_ arburst  in  2  burst type
s0_/s1_ arid  in  ID_WIDTH  transaction ID
s0_/s1_ arvalid  in  1  AR request
s0_/s1_ arready  out  1  AR accept
s0_/s1_ rdata  out  DATA_WIDTH  read data (shared broadcast)
s0_/s1_ rresp  out  2  read response (shared broadcast)
s0_/s1_ rid  out  ID_WIDTH  read ID (shared broadcast)
s0_/s1_ rlast  out  1  last beat (shared broadcast)
s0_/s1_ rvalid  out  1  beat valid (granted port only)
s0_/s1_ rready  in  1  beat accept
m00_axi_araddr/arlen/arsize/arburst/arid  out  as above  registered AR fields
m00_axi_arlock/arcache/arprot/arqos  out  2/4/3/4  constants 0 / 4'b0011 / 0 / 0
m00_axi_arvalid  out  1  AR valid
m00_axi_arready  in  1  AR ready
m00_axi_rdata/rresp/rid/rlast/rvalid  in  as above  downstream R beat
m00_axi_rready  out  1  R ready
grant_o  out  1  current/last owner (0=s0, 1=s1)
busy_o  out  1  state != IDLE
err_o  out  2  sticky: [0] rlast/len mismatch, [1] rid mismatch

Behaviour:
- Single clock; every register resets synchronously when m00_axi_aresetn=0.
- Reset values: state=IDLE, m00_axi_arvalid=0, m00_axi_rready=0, sN_arready=0, sN_rvalid=0, grant_o=1 (so s0 wins first), busy_o=0, err_o=0, AR field registers=0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Only s0 arvalid: grant s0. Only s1 arvalid: grant s1. Both: grant the port != grant_o.
  - In the grant cycle, pulse the winner's arready for exactly 1 cycle (AR handshake with the requester), latch its AR fields and arid, update grant_o, go to ADDR.
  - The loser's arready stays 0.
- ADDR:
  - m00_axi_arvalid=1 with the latched fields, held stable until m00_axi_arready.
  - On the handshake: load beat counter=arlen, go to DATA.
  - AR latency from sN_arvalid to m00_axi_arvalid is 2 cycles minimum.
- DATA (combinational R path):
  - s[grant]_rvalid = m00_axi_rvalid; m00_axi_rready = s[grant]_rready.
  - The other port's rvalid=0. Data, resp, id and last are broadcast to both ports.
  - On each beat handshake: decrement the counter.
  - If rid != latched arid, set err_o[1].
  - rlast with counter != 0, or counter == 0 without rlast: set err_o[0].
  - The burst always ends on the rlast handshake. Go to IDLE, no pointer change beyond the grant already recorded.
  - The counter does not decrement below 0; extra beats are still forwarded.
- Arbitration happens only in IDLE. Requests arriving in ADDR/DATA wait, and their arready stays 0.
- There is a 1-cycle IDLE bubble between consecutive bursts.
- A requester deasserting arvalid before grant is tolerated (no grant issued).
- err_o bits are sticky and cleared only by reset.
- Reset mid-burst: the arbiter returns to IDLE at the next edge and in-flight beats are dropped. The m00 slave must share this reset.
- arsize/arburst pass through unchecked. arlen is 4 bits (1–16 beats).

Test Plan:
- Reset with s0/s1 arvalid held high -> all outputs at reset values. First grant after release goes to s0 (grant_o=0); s0_arready pulses 1 cycle.
- s0 araddr=0x1000_0000, arlen=3, arid=5; slave returns 4 beats with rlast on beat 4, rid=5 -> m00_axi_araddr=0x1000_0000, arlen=3; s0 receives 4 beats; s1_rvalid=0 throughout; err_o=0; busy_o falls after rlast.
- Both requesters continuously requesting arlen=0 bursts -> grants alternate s0,s1,s0,s1 with 1 IDLE cycle between bursts.
- m00_axi_arready held 0 for 5 cycles, then 1 -> m00_axi_arvalid stays 1 and AR fields stay stable for 6 cycles; single AR handshake.
- s1 asserts arvalid during an s0 DATA phase where s0_rready toggles 1,0,1 -> beats stall on m00_axi_rready=0; s1 is granted only after s0 rlast plus the bubble cycle.
- Early rlast on beat 2 of arlen=3, then rid=7 vs arid=2 on the next burst -> err_o=2'b01 after the first burst, then 2'b11. Both bits stay set until reset.

Source files
------------

// File: rtl/axi3_rd_arbiter.sv
// Round-robin arbiter that shares one AXI3 read channel (AR + R) between two requesters.
// One burst is in flight at a time; R beats go back to the owner, and protocol errors are flagged in sticky bits.
module axi3_rd_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 6
) (
   input  logic                  m00_axi_aclk,
   input  logic                  m00_axi_aresetn,

   input  logic [ADDR_WIDTH-1:0] s0_araddr,
   input  logic [3:0]            s0_arlen,
   input  logic [2:0]            s0_arsize,
   input  logic [1:0]            s0_arburst,
   input  logic [ID_WIDTH-1:0]   s0_arid,
   input  logic                  s0_arvalid,
   output logic                  s0_arready,
   output logic [DATA_WIDTH-1:0] s0_rdata,
   output logic [1:0]            s0_rresp,
   output logic [ID_WIDTH-1:0]   s0_rid,
   output logic                  s0_rlast,
   output logic                  s0_rvalid,
   input  logic                  s0_rready,

   input  logic [ADDR_WIDTH-1:0] s1_araddr,
   input  logic [3:0]            s1_arlen,
   input  logic [2:0]            s1_arsize,
   input  logic [1:0]            s1_arburst,
   input  logic [ID_WIDTH-1:0]   s1_arid,
   input  logic                  s1_arvalid,
   output logic                  s1_arready,
   output logic [DATA_WIDTH-1:0] s1_rdata,
   output logic [1:0]            s1_rresp,
   output logic [ID_WIDTH-1:0]   s1_rid,
   output logic                  s1_rlast,
   output logic                  s1_rvalid,
   input  logic                  s1_rready,

   output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
   output logic [3:0]            m00_axi_arlen,
   output logic [2:0]            m00_axi_arsize,
   output logic [1:0]            m00_axi_arburst,
   output logic [ID_WIDTH-1:0]   m00_axi_arid,
   output logic [1:0]            m00_axi_arlock,
   output logic [3:0]            m00_axi_arcache,
   output logic [2:0]            m00_axi_arprot,
   output logic [3:0]            m00_axi_arqos,
   output logic                  m00_axi_arvalid,
   input  logic                  m00_axi_arready,
   input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
   input  logic [1:0]            m00_axi_rresp,
   input  logic [ID_WIDTH-1:0]   m00_axi_rid,
   input  logic                  m00_axi_rlast,
   input  logic                  m00_axi_rvalid,
   output logic                  m00_axi_rready,

   output logic                  grant_o,
   output logic                  busy_o,
   output logic [1:0]            err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                state_reg;
   logic                  grant_reg;
   logic [1:0]            arready_reg;
   logic                  m00_arvalid_reg;
   logic [ADDR_WIDTH-1:0] araddr_reg;
   logic [3:0]            arlen_reg;
   logic [2:0]            arsize_reg;
   logic [1:0]            arburst_reg;
   logic [ID_WIDTH-1:0]   arid_reg;
   logic [3:0]            beat_cnt_reg;
   logic [1:0]            err_reg;

   // Requester views as two-entry arrays so the FSM can index by the winner.
   logic [1:0]            req_valid;
   logic [1:0]            req_rready;
   logic [ADDR_WIDTH-1:0] req_addr  [2];
   logic [3:0]            req_len   [2];
   logic [2:0]            req_size  [2];
   logic [1:0]            req_burst [2];
   logic [ID_WIDTH-1:0]   req_id    [2];

   assign req_valid    = {s1_arvalid, s0_arvalid};
   assign req_rready   = {s1_rready, s0_rready};
   assign req_addr[0]  = s0_araddr;
   assign req_addr[1]  = s1_araddr;
   assign req_len[0]   = s0_arlen;
   assign req_len[1]   = s1_arlen;
   assign req_size[0]  = s0_arsize;
   assign req_size[1]  = s1_arsize;
   assign req_burst[0] = s0_arburst;
   assign req_burst[1] = s1_arburst;
   assign req_id[0]    = s0_arid;
   assign req_id[1]    = s1_arid;

   logic       winner;
   logic       in_data;
   logic       beat_hs;
   logic [1:0] s_rvalid;

   // With both requesting, the port that did not own the last burst wins.
   always_comb begin
      winner = req_valid[1];
      if (req_valid == 2'b11)
         winner = ~grant_reg;
   end

   assign in_data        = (state_reg == DATA);
   assign m00_axi_rready = in_data && req_rready[grant_reg];
   assign beat_hs        = m00_axi_rvalid && m00_axi_rready;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
         assign s_rvalid[gi] = in_data && (grant_reg == 1'(gi)) && m00_axi_rvalid;
      end
   endgenerate

   always_ff @(posedge m00_axi_aclk) begin
      if (!m00_axi_aresetn) begin
         state_reg       <= IDLE;
         grant_reg       <= 1'b1;
         arready_reg     <= 2'b00;
         m00_arvalid_reg <= 1'b0;
         araddr_reg      <= '0;
         arlen_reg       <= '0;
         arsize_reg      <= '0;
         arburst_reg     <= '0;
         arid_reg        <= '0;
         beat_cnt_reg    <= '0;
         err_reg         <= 2'b00;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid != 2'b00) begin
                  grant_reg           <= winner;
                  arready_reg[winner] <= 1'b1;
                  araddr_reg          <= req_addr[winner];
                  arlen_reg           <= req_len[winner];
                  arsize_reg          <= req_size[winner];
                  arburst_reg         <= req_burst[winner];
                  arid_reg            <= req_id[winner];
                  state_reg           <= ADDR;
               end
            end

            ADDR: begin
               // First ADDR cycle is the requester-side arready pulse; the downstream AR follows it.
               if (arready_reg != 2'b00) begin
                  arready_reg     <= 2'b00;
                  m00_arvalid_reg <= 1'b1;
               end else if (m00_arvalid_reg && m00_axi_arready) begin
                  m00_arvalid_reg <= 1'b0;
                  beat_cnt_reg    <= arlen_reg;
                  state_reg       <= DATA;
               end
            end

            DATA: begin
               if (beat_hs) begin
                  if (m00_axi_rid != arid_reg)
                     err_reg[1] <= 1'b1;
                  if (m00_axi_rlast != (beat_cnt_reg == 4'd0))
                     err_reg[0] <= 1'b1;
                  if (beat_cnt_reg != 4'd0)
                     beat_cnt_reg <= beat_cnt_reg - 4'd1;
                  if (m00_axi_rlast)
                     state_reg <= IDLE;
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

   assign s0_arready      = arready_reg[0];
   assign s1_arready      = arready_reg[1];

   assign s0_rvalid       = s_rvalid[0];
   assign s1_rvalid       = s_rvalid[1];
   assign s0_rdata        = m00_axi_rdata;
   assign s1_rdata        = m00_axi_rdata;
   assign s0_rresp        = m00_axi_rresp;
   assign s1_rresp        = m00_axi_rresp;
   assign s0_rid          = m00_axi_rid;
   assign s1_rid          = m00_axi_rid;
   assign s0_rlast        = m00_axi_rlast;
   assign s1_rlast        = m00_axi_rlast;

   assign m00_axi_araddr  = araddr_reg;
   assign m00_axi_arlen   = arlen_reg;
   assign m00_axi_arsize  = arsize_reg;
   assign m00_axi_arburst = arburst_reg;
   assign m00_axi_arid    = arid_reg;
   assign m00_axi_arlock  = 2'b00;
   assign m00_axi_arcache = 4'b0011;
   assign m00_axi_arprot  = 3'b000;
   assign m00_axi_arqos   = 4'b0000;
   assign m00_axi_arvalid = m00_arvalid_reg;

   assign grant_o         = grant_reg;
   assign busy_o          = (state_reg != IDLE);
   assign err_o           = err_reg;

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// Directed bench for axi3_rd_arbiter: the bench plays both requesters and the m00 read slave.
module tb_axi3_rd_arbiter;

   logic        clk = 1'b0;
   logic        aresetn;
   logic [31:0] s0_araddr, s1_araddr;
   logic [3:0]  s0_arlen, s1_arlen;
   logic [2:0]  s0_arsize, s1_arsize;
   logic [1:0]  s0_arburst, s1_arburst;
   logic [5:0]  s0_arid, s1_arid;
   logic        s0_arvalid, s1_arvalid;
   logic        s0_arready, s1_arready;
   logic [63:0] s0_rdata, s1_rdata;
   logic [1:0]  s0_rresp, s1_rresp;
   logic [5:0]  s0_rid, s1_rid;
   logic        s0_rlast, s1_rlast;
   logic        s0_rvalid, s1_rvalid;
   logic        s0_rready, s1_rready;
   logic [31:0] m00_axi_araddr;
   logic [3:0]  m00_axi_arlen;
   logic [2:0]  m00_axi_arsize;
   logic [1:0]  m00_axi_arburst;
   logic [5:0]  m00_axi_arid;
   logic [1:0]  m00_axi_arlock;
   logic [3:0]  m00_axi_arcache;
   logic [2:0]  m00_axi_arprot;
   logic [3:0]  m00_axi_arqos;
   logic        m00_axi_arvalid, m00_axi_arready;
   logic [63:0] m00_axi_rdata;
   logic [1:0]  m00_axi_rresp;
   logic [5:0]  m00_axi_rid;
   logic        m00_axi_rlast, m00_axi_rvalid, m00_axi_rready;
   logic        grant_o, busy_o;
   logic [1:0]  err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi3_rd_arbiter dut (
      .m00_axi_aclk(clk), .m00_axi_aresetn(aresetn),
      .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
      .s0_arid(s0_arid), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
      .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rid(s0_rid), .s0_rlast(s0_rlast),
      .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
      .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
      .s1_arid(s1_arid), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
      .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rid(s1_rid), .s1_rlast(s1_rlast),
      .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
      .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen), .m00_axi_arsize(m00_axi_arsize),
      .m00_axi_arburst(m00_axi_arburst), .m00_axi_arid(m00_axi_arid), .m00_axi_arlock(m00_axi_arlock),
      .m00_axi_arcache(m00_axi_arcache), .m00_axi_arprot(m00_axi_arprot), .m00_axi_arqos(m00_axi_arqos),
      .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
      .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp), .m00_axi_rid(m00_axi_rid),
      .m00_axi_rlast(m00_axi_rlast), .m00_axi_rvalid(m00_axi_rvalid), .m00_axi_rready(m00_axi_rready),
      .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic issue_ar(input int port, input logic [31:0] addr, input logic [3:0] len,
                           input logic [5:0] id);
      if (port == 0) begin
         s0_araddr = addr; s0_arlen = len; s0_arid = id; s0_arvalid = 1'b1;
      end else begin
         s1_araddr = addr; s1_arlen = len; s1_arid = id; s1_arvalid = 1'b1;
      end
   endtask

   // Entered just after the grant edge; ends just after the m00 AR handshake edge (DATA phase).
   task automatic addr_phase(input int port, input logic [31:0] addr, input logic [3:0] len,
                             input logic [5:0] id, input int stall, input bit keep);
      logic p;
      p = port[0];
      chk("grant_o", grant_o, p);
      chk("win_arready", (p ? s1_arready : s0_arready), 1);
      chk("lose_arready", (p ? s0_arready : s1_arready), 0);
      chk("busy_grant", busy_o, 1);
      chk("arvalid_latency", m00_axi_arvalid, 0);
      tick();
      if (!keep) begin
         if (p) s1_arvalid = 1'b0;
         else   s0_arvalid = 1'b0;
      end
      chk("arready_pulse_end", {s1_arready, s0_arready}, 2'b00);
      for (int i = 0; i < stall; i++) begin
         chk("arvalid_hold", m00_axi_arvalid, 1);
         chk("araddr_hold", m00_axi_araddr, addr);
         tick();
      end
      m00_axi_arready = 1'b1;
      chk("arvalid", m00_axi_arvalid, 1);
      chk("araddr", m00_axi_araddr, addr);
      chk("arlen", m00_axi_arlen, len);
      chk("arid", m00_axi_arid, id);
      chk("arcache", m00_axi_arcache, 4'b0011);
      tick();
      m00_axi_arready = 1'b0;
      chk("arvalid_after_hs", m00_axi_arvalid, 0);
      chk("busy_data", busy_o, 1);
      $display("AR  port=%0d addr=%h len=%0d id=%0d stall=%0d", port, addr, len, id, stall);
   endtask

   // Presents one R beat for one cycle; the non-owner's rready is held 1 to show it is ignored.
   task automatic beat(input int port, input logic [63:0] d, input logic [5:0] id,
                       input bit last, input bit rdy);
      logic p;
      p = port[0];
      m00_axi_rvalid = 1'b1; m00_axi_rdata = d; m00_axi_rid = id; m00_axi_rlast = last;
      s0_rready = p ? 1'b1 : rdy;
      s1_rready = p ? rdy : 1'b1;
      #1;
      chk("own_rvalid", (p ? s1_rvalid : s0_rvalid), 1);
      chk("other_rvalid", (p ? s0_rvalid : s1_rvalid), 0);
      chk("m00_rready", m00_axi_rready, rdy);
      chk("own_rdata", (p ? s1_rdata : s0_rdata), d);
      chk("bcast_rdata", (p ? s0_rdata : s1_rdata), d);
      chk("own_rlast", (p ? s1_rlast : s0_rlast), last);
      @(posedge clk);
      #1;
      m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0;
      s0_rready = 1'b0; s1_rready = 1'b0;
      $display("R   port=%0d data=%h id=%0d last=%0d rready=%0d err=%b", port, d, id, last, rdy, err_o);
   endtask

   initial begin
      logic exp_g;
      aresetn = 1'b0;
      s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd3; s0_arburst = 2'b01; s0_arid = '0;
      s1_araddr = '0; s1_arlen = '0; s1_arsize = 3'd3; s1_arburst = 2'b01; s1_arid = '0;
      s0_arvalid = 1'b1; s1_arvalid = 1'b1; s0_rready = 1'b0; s1_rready = 1'b0;
      m00_axi_arready = 1'b0; m00_axi_rdata = '0; m00_axi_rresp = '0; m00_axi_rid = '0;
      m00_axi_rlast = 1'b0; m00_axi_rvalid = 1'b0;

      // Reset held with both requesters asserting arvalid.
      repeat (3) tick();
      chk("rst_grant", grant_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 2'b00);
      chk("rst_arready", {s1_arready, s0_arready}, 2'b00);
      chk("rst_arvalid", m00_axi_arvalid, 0);
      chk("rst_rready", m00_axi_rready, 0);
      chk("rst_araddr", m00_axi_araddr, 0);
      $display("RST grant=%0d busy=%0d err=%b", grant_o, busy_o, err_o);

      // First grant after reset goes to s0; basic 4-beat burst.
      issue_ar(0, 32'h1000_0000, 4'd3, 6'd5);
      issue_ar(1, 32'h1100_0000, 4'd0, 6'd6);
      aresetn = 1'b1;
      tick();
      s1_arvalid = 1'b0;
      addr_phase(0, 32'h1000_0000, 4'd3, 6'd5, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         beat(0, 64'hA000 + 64'(i), 6'd5, (i == 3), 1'b1);
         chk("busy_burst", busy_o, (i != 3));
      end
      chk("err_clean", err_o, 2'b00);

      // s1 alone with the downstream arready held off for 5 cycles.
      issue_ar(1, 32'h2000_0040, 4'd0, 6'd9);
      tick();
      addr_phase(1, 32'h2000_0040, 4'd0, 6'd9, 5, 1'b0);
      beat(1, 64'hB0B0, 6'd9, 1'b1, 1'b1);
      chk("busy_idle_s1", busy_o, 0);

      // Both requesting single-beat bursts continuously: grants alternate with one idle cycle.
      issue_ar(0, 32'h3000_0000, 4'd0, 6'd1);
      issue_ar(1, 32'h3100_0000, 4'd0, 6'd2);
      tick();
      exp_g = 1'b0;
      for (int k = 0; k < 4; k++) begin
         addr_phase(exp_g ? 1 : 0, exp_g ? 32'h3100_0000 : 32'h3000_0000, 4'd0,
                    exp_g ? 6'd2 : 6'd1, 0, 1'b1);
         beat(exp_g ? 1 : 0, 64'hC000 + 64'(k), exp_g ? 6'd2 : 6'd1, 1'b1, 1'b1);
         chk("bubble_busy", busy_o, 0);
         chk("bubble_arready", {s1_arready, s0_arready}, 2'b00);
         if (k == 3) begin
            s0_arvalid = 1'b0; s1_arvalid = 1'b0;
         end
         tick();
         exp_g = ~exp_g;
      end
      chk("alt_done_busy", busy_o, 0);

      // s1 requests during an s0 burst whose rready toggles 1,0,1.
      issue_ar(0, 32'h4000_0000, 4'd2, 6'd3);
      tick();
      addr_phase(0, 32'h4000_0000, 4'd2, 6'd3, 0, 1'b0);
      issue_ar(1, 32'h4100_0000, 4'd0, 6'd4);
      beat(0, 64'hD000, 6'd3, 1'b0, 1'b1);
      beat(0, 64'hD001, 6'd3, 1'b0, 1'b0);
      chk("wait_arready_s1", s1_arready, 0);
      chk("stall_busy", busy_o, 1);
      beat(0, 64'hD001, 6'd3, 1'b0, 1'b1);
      chk("wait_arready_s1b", s1_arready, 0);
      beat(0, 64'hD002, 6'd3, 1'b1, 1'b1);
      chk("post_rlast_busy", busy_o, 0);
      chk("post_rlast_arready", s1_arready, 0);
      tick();
      addr_phase(1, 32'h4100_0000, 4'd0, 6'd4, 0, 1'b0);
      beat(1, 64'hD100, 6'd4, 1'b1, 1'b1);
      chk("err_still_clean", err_o, 2'b00);

      // Early rlast on beat 2 of a 4-beat burst, then an rid mismatch.
      issue_ar(0, 32'h5000_0000, 4'd3, 6'd2);
      tick();
      addr_phase(0, 32'h5000_0000, 4'd3, 6'd2, 0, 1'b0);
      beat(0, 64'hE000, 6'd2, 1'b0, 1'b1);
      chk("err_before_early", err_o, 2'b00);
      beat(0, 64'hE001, 6'd2, 1'b1, 1'b1);
      chk("err_early_rlast", err_o, 2'b01);
      chk("early_ends_burst", busy_o, 0);
      issue_ar(1, 32'h5100_0000, 4'd0, 6'd2);
      tick();
      addr_phase(1, 32'h5100_0000, 4'd0, 6'd2, 0, 1'b0);
      beat(1, 64'hE100, 6'd7, 1'b1, 1'b1);
      chk("err_rid", err_o, 2'b11);
      issue_ar(0, 32'h5200_0000, 4'd0, 6'd8);
      tick();
      addr_phase(0, 32'h5200_0000, 4'd0, 6'd8, 0, 1'b0);
      beat(0, 64'hE200, 6'd8, 1'b1, 1'b1);
      chk("err_sticky", err_o, 2'b11);

      // Reset in the middle of a burst returns to idle and clears the error flags.
      issue_ar(1, 32'h6000_0000, 4'd1, 6'd1);
      tick();
      addr_phase(1, 32'h6000_0000, 4'd1, 6'd1, 0, 1'b0);
      m00_axi_rvalid = 1'b1; m00_axi_rid = 6'd1; s1_rready = 1'b1;
      aresetn = 1'b0;
      tick();
      chk("midrst_busy", busy_o, 0);
      chk("midrst_rvalid", s1_rvalid, 0);
      chk("midrst_rready", m00_axi_rready, 0);
      chk("midrst_err", err_o, 2'b00);
      chk("midrst_grant", grant_o, 1);
      $display("RST mid-burst busy=%0d err=%b grant=%0d", busy_o, err_o, grant_o);
      m00_axi_rvalid = 1'b0; s1_rready = 1'b0;
      aresetn = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
